// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the byte-wide memory sequencer
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  localparam logic [1:0] WT_BYTE = 2'b00;
  localparam logic [1:0] WT_HALF = 2'b01;
  localparam logic [1:0] WT_WORD = 2'b11;

  // UART/IO window is selected by address bits [17:16]
  localparam logic [1:0] IO_SEL = 2'b11;

  function automatic logic [2:0] size_of(input logic [1:0] wt);
    case (wt)
      WT_BYTE: return 3'd1;
      WT_HALF: return 3'd2;
      WT_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/LSB grant selection
// MEM_CTRL_RR_EN: alternate grants on contention instead of fixed LSB priority.
module mem_arbiter (
`ifdef MEM_CTRL_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic if_req,
  input  logic lsb_req,
  output logic grant_if,
  output logic grant_lsb
);

`ifdef MEM_CTRL_RR_EN
  // set when the fetcher should win the next contended grant
  logic prio_if;

  always_ff @(posedge clk) begin
    if (rst)
      prio_if <= 1'b1;
    else if (take)
      prio_if <= grant_lsb;
  end

  assign grant_lsb = lsb_req && (!if_req || !prio_if);
`else
  assign grant_lsb = lsb_req;
`endif

  assign grant_if = if_req && !grant_lsb;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - serialises fetch and LSB requests onto the byte-wide RAM/IO port
// MEM_CTRL_RR_EN selects round-robin arbitration in mem_arbiter.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  _clear,
  input  logic                  _if_mem_ready,
  input  logic [ADDR_WIDTH-1:0] _if_addr,
  output logic                  _if_mem_done,
  output logic [31:0]           _if_mem_data,
  input  logic                  _lsb_mem_ready,
  input  logic [1:0]            _work_type,
  input  logic                  _r_nw_in,
  input  logic [ADDR_WIDTH-1:0] _addr,
  input  logic [31:0]           _data_in,
  output logic                  _mem_busy,
  output logic                  _mem_lsb_ready,
  output logic [31:0]           _data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  state_t      state, next_state;
  logic [2:0]  size, iss, cap;
  logic [23:0] wdata, shreg;
  logic [31:0] rd_word;
  logic        mem_wr_q, cap_pend, orphan;
  logic        grant_if, grant_lsb, accept, issuing, capturing, finish, io_stall;

  mem_arbiter u_arb (
`ifdef MEM_CTRL_RR_EN
    .clk       (clk_in),
    .rst       (rst_in),
    .take      (accept),
`endif
    .if_req    (_if_mem_ready),
    .lsb_req   (_lsb_mem_ready),
    .grant_if  (grant_if),
    .grant_lsb (grant_lsb)
  );

  assign io_stall  = is_io(mem_a[17:16]) && io_buffer_full;
  assign mem_wr    = mem_wr_q && rdy_in && !io_stall;
  assign _mem_busy = (state != IDLE);
  assign rd_word   = {mem_din, shreg};

  always_ff @(posedge clk_in) begin
    if (rst_in)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issuing    = 1'b0;
    capturing  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        accept = rdy_in && !_clear && (grant_if || grant_lsb);
        if (accept)
          next_state = grant_if ? IF_RD : (_r_nw_in ? LS_WR : LS_RD);
      end
      IF_RD, LS_RD: begin
        issuing   = rdy_in && (iss < size);
        capturing = cap_pend;
        finish    = cap_pend && (cap + 3'd1 == size);
        if (_clear || finish)
          next_state = IDLE;
      end
      LS_WR: begin
        issuing = rdy_in && !io_stall;
        finish  = issuing && (iss + 3'd1 == size);
        if (finish)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr_q       <= 1'b0;
      size           <= '0;
      iss            <= '0;
      cap            <= '0;
      wdata          <= '0;
      shreg          <= '0;
      cap_pend       <= 1'b0;
      orphan         <= 1'b0;
      _if_mem_done   <= 1'b0;
      _if_mem_data   <= '0;
      _mem_lsb_ready <= 1'b0;
      _data_out      <= '0;
    end else begin
      _if_mem_done   <= 1'b0;
      _mem_lsb_ready <= 1'b0;
      // a read byte arrives the cycle after its issue; an abort drops it
      cap_pend <= issuing && (state != LS_WR) && !_clear;

      if (accept) begin
        mem_a    <= grant_lsb ? _addr : _if_addr;
        size     <= grant_lsb ? size_of(_work_type) : 3'd4;
        mem_wr_q <= grant_lsb && _r_nw_in;
        mem_dout <= _data_in[7:0];
        wdata    <= _data_in[31:8];
        iss      <= '0;
        cap      <= '0;
        shreg    <= '0;
        orphan   <= 1'b0;
      end

      if (issuing) begin
        iss <= iss + 3'd1;
        if (iss + 3'd1 < size) begin
          mem_a    <= mem_a + ADDR_WIDTH'(1);
          mem_dout <= wdata[7:0];
          wdata    <= {8'h00, wdata[23:8]};
        end
      end

      if (capturing) begin
        shreg <= rd_word[31:8];
        cap   <= cap + 3'd1;
      end

      // a flushed store still drains to RAM but must not signal the new LSB head
      if (state == LS_WR && _clear)
        orphan <= 1'b1;

      if (finish) begin
        mem_wr_q <= 1'b0;
        if (!_clear && !orphan) begin
          if (state == IF_RD) begin
            _if_mem_done <= 1'b1;
            _if_mem_data <= rd_word;
          end else if (state == LS_RD) begin
            _mem_lsb_ready <= 1'b1;
            _data_out      <= rd_word;
          end else begin
            _mem_lsb_ready <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a synchronous byte RAM model
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        if_mem_ready, if_mem_done;
  logic [31:0] if_addr, if_mem_data;
  logic        lsb_mem_ready, r_nw_in, mem_busy, mem_lsb_ready;
  logic [1:0]  work_type;
  logic [31:0] addr, data_in, data_out;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  typedef struct {logic [31:0] data; logic [31:0] cyc; bit chk;} exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d; logic [31:0] cyc;} wr_t;

  exp_t        lsb_q[$];
  exp_t        if_q[$];
  wr_t         wr_q[$];
  logic [7:0]  rom [0:262143];
  logic [31:0] cyc = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    ._clear         (clear),
    ._if_mem_ready  (if_mem_ready),
    ._if_addr       (if_addr),
    ._if_mem_done   (if_mem_done),
    ._if_mem_data   (if_mem_data),
    ._lsb_mem_ready (lsb_mem_ready),
    ._work_type     (work_type),
    ._r_nw_in       (r_nw_in),
    ._addr          (addr),
    ._data_in       (data_in),
    ._mem_busy      (mem_busy),
    ._mem_lsb_ready (mem_lsb_ready),
    ._data_out      (data_out),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc     <= cyc + 32'd1;
    mem_din <= rom[mem_a[17:0]];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    wr_t  w;
    if (!rst_in) begin
      if (mem_lsb_ready) begin
        if (lsb_q.size() == 0) check("lsb_unexp", 32'(mem_lsb_ready), 32'd0);
        else begin
          e = lsb_q.pop_front();
          check("lsb_cyc", cyc, e.cyc);
          if (e.chk) check("lsb_data", data_out, e.data);
        end
      end
      if (if_mem_done) begin
        if (if_q.size() == 0) check("if_unexp", 32'(if_mem_done), 32'd0);
        else begin
          e = if_q.pop_front();
          check("if_cyc", cyc, e.cyc);
          check("if_data", if_mem_data, e.data);
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) check("wr_unexp", 32'(mem_wr), 32'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_a, w.a);
          check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
          check("wr_cyc", cyc, w.cyc);
        end
      end
    end
  end

  task automatic lsb_go(input logic [1:0] wt, input logic st, input logic [31:0] a, input logic [31:0] d);
    lsb_mem_ready = 1'b1;
    work_type     = wt;
    r_nw_in       = st;
    addr          = a;
    data_in       = d;
    @(posedge clk_in); #1;
    lsb_mem_ready = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (12) @(posedge clk_in);
    #1;
    check({tag, "_drain"}, 32'(lsb_q.size() + if_q.size() + wr_q.size()), 32'd0);
    lsb_q.delete();
    if_q.delete();
    wr_q.delete();
  endtask

  task automatic both_go();
    if_mem_ready  = 1'b1;
    if_addr       = 32'h1400;
    lsb_mem_ready = 1'b1;
    work_type     = 2'b00;
    r_nw_in       = 1'b0;
    addr          = 32'h1800;
    @(posedge clk_in); #1;
    if_mem_ready  = 1'b0;
    lsb_mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] c0;
    for (int i = 0; i < 262144; i++) rom[i] = 8'h00;
    rom['h1000] = 8'h11; rom['h1001] = 8'h22; rom['h1002] = 8'h33; rom['h1003] = 8'h44;
    rom['h1400] = 8'h01; rom['h1401] = 8'h02; rom['h1402] = 8'h03; rom['h1403] = 8'h04;
    rom['h1800] = 8'h80; rom['h1801] = 8'h5A;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_mem_ready = 1'b0; if_addr = '0; lsb_mem_ready = 1'b0;
    work_type = '0; r_nw_in = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_a", mem_a, 32'd0);
    check("rst_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_if_data", if_mem_data, 32'd0);
    check("rst_pulses", {30'd0, if_mem_done, mem_lsb_ready}, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    c0 = cyc;
    lsb_q.push_back('{32'h44332211, c0 + 6, 1'b1});
    lsb_go(2'b11, 1'b0, 32'h1000, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      check("busy_wload", 32'(mem_busy), 32'(k <= 5));
      @(posedge clk_in); #1;
    end
    settle("wload");

    rom['h1002] = 8'h34; rom['h1003] = 8'h12;
    c0 = cyc;
    lsb_q.push_back('{32'h12340000, c0 + 4, 1'b1});
    lsb_go(2'b01, 1'b0, 32'h1002, 32'd0);
    settle("hload");

    c0 = cyc;
    lsb_q.push_back('{32'h80000000, c0 + 3, 1'b1});
    lsb_go(2'b00, 1'b0, 32'h1800, 32'd0);
    settle("bload");

    c0 = cyc;
    lsb_q.push_back('{32'h5A000000, c0 + 3, 1'b1});
    lsb_go(2'b10, 1'b0, 32'h1801, 32'd0);
    settle("wt10");

    c0 = cyc;
    wr_q.push_back('{32'h2000, 8'hCD, c0 + 1});
    wr_q.push_back('{32'h2001, 8'hAB, c0 + 2});
    lsb_q.push_back('{32'd0, c0 + 3, 1'b0});
    lsb_go(2'b01, 1'b1, 32'h2000, 32'h0000ABCD);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("busy_done", 32'(mem_busy), 32'd0);
    c0 = cyc;
    lsb_q.push_back('{32'h80000000, c0 + 3, 1'b1});
    lsb_go(2'b00, 1'b0, 32'h1800, 32'd0);
    settle("b2b");

    c0 = cyc;
`ifdef MEM_CTRL_RR_EN
    if_q.push_back('{32'h04030201, c0 + 6, 1'b1});
`else
    lsb_q.push_back('{32'h80000000, c0 + 3, 1'b1});
`endif
    both_go();
    settle("arb1");
    c0 = cyc;
    lsb_q.push_back('{32'h80000000, c0 + 3, 1'b1});
    both_go();
    settle("arb2");

    c0 = cyc;
    wr_q.push_back('{32'h30000, 8'h41, c0 + 4});
    lsb_q.push_back('{32'd0, c0 + 5, 1'b0});
    io_buffer_full = 1'b1;
    lsb_go(2'b00, 1'b1, 32'h30000, 32'h00000041);
    repeat (3) begin @(posedge clk_in); #1; end
    io_buffer_full = 1'b0;
    settle("io");

    if_mem_ready = 1'b1;
    if_addr      = 32'h1400;
    repeat (3) begin @(posedge clk_in); #1; end
    clear        = 1'b1;
    if_mem_ready = 1'b0;
    @(posedge clk_in); #1;
    clear = 1'b0;
    check("clr_idle", 32'(mem_busy), 32'd0);
    settle("clr_fetch");

    c0 = cyc;
    wr_q.push_back('{32'h2100, 8'h78, c0 + 1});
    wr_q.push_back('{32'h2101, 8'h56, c0 + 2});
    wr_q.push_back('{32'h2102, 8'h34, c0 + 3});
    wr_q.push_back('{32'h2103, 8'h12, c0 + 4});
    lsb_go(2'b11, 1'b1, 32'h2100, 32'h12345678);
    @(posedge clk_in); #1;
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    settle("clr_store");

    rom['h1002] = 8'h33; rom['h1003] = 8'h44;
    c0 = cyc;
    lsb_q.push_back('{32'h44332211, c0 + 8, 1'b1});
    lsb_go(2'b11, 1'b0, 32'h1000, 32'd0);
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    check("rdy_hold2", mem_a, 32'h1001);
    @(posedge clk_in); #1;
    check("rdy_hold3", mem_a, 32'h1001);
    @(posedge clk_in); #1;
    rdy_in = 1'b1;
    settle("rdy");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Sequencer and arbiter for the single byte-wide RAM/IO port, shared between the instruction fetcher (word reads) and the load/store buffer (byte/half/word loads and committed stores). It serialises each request into one RAM access per cycle, assembles read bytes into the left-aligned result format the LSB expects, and pulses completion back to the requester.

## Interface
- ADDR_WIDTH, 32, width of request addresses and `mem_a`
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global pause; low freezes issue
- _clear  in  1  pipeline flush (mispredict)
- _if_mem_ready  in  1  fetch request; held until `_if_mem_done`
- _if_addr  in  ADDR_WIDTH  fetch address, stable while requesting
- _if_mem_done  out  1  one-cycle fetch completion pulse
- _if_mem_data  out  32  fetched word, valid with `_if_mem_done`
- _lsb_mem_ready  in  1  LSB request
- _work_type  in  2  size: 00 byte, 01 half, 11 word, 10 treated as byte
- _r_nw_in  in  1  1 = store, 0 = load
- _addr  in  ADDR_WIDTH  LSB access address
- _data_in  in  32  store data, right-aligned
- _mem_busy  out  1  controller not idle
- _mem_lsb_ready  out  1  one-cycle LSB completion pulse
- _data_out  out  32  load result, left-aligned, valid with `_mem_lsb_ready`
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  UART FIFO full

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR.
- In IDLE, a request (rdy_in high, _clear low) is latched: address, size N (1/2/4), direction, data, owner. The fetcher always uses N=4 and reads only.
- Arbitration in IDLE: if only one requester is active, it is granted. If both are active, the LSB wins (see Configuration).
- Reads: byte i is issued at addr+i with mem_wr=0. The RAM returns the byte one cycle later. Each returned byte is shifted in at [31:24] while the register shifts right by 8. The shift register is zeroed at acceptance. Result: word {b3,b2,b1,b0}; half in [31:16]; byte in [31:24]; lower bits zero.
- Capture happens on every cycle that follows an issue cycle, independent of rdy_in.
- Writes: byte i = _data_in[8i+7:8i] goes to addr+i with mem_wr=1.
- IO stall: if the address has addr[17:16]==2'b11 and io_buffer_full is high, the write byte is held with mem_wr=0 until io_buffer_full is low.
- rdy_in low: no new issue and no state advance. mem_wr is forced to 0 combinationally and mem_a is held. The pending byte is reissued when rdy_in returns high.
- After the last byte (captured for reads, written for stores), the FSM returns to IDLE. In the same cycle, the registered done pulse and data go to the owner.
- _mem_busy is high in IF_RD, LS_RD and LS_WR only, and low in the done cycle. A new request presented in the done cycle is accepted, which gives back-to-back operation with the LSB's next-head lookahead.
- _clear during a read: the read is aborted, the FSM goes to IDLE next cycle, and no done pulse is produced.
- _clear during LS_WR: the store is committed, so it completes all bytes. Its `_mem_lsb_ready` is suppressed via a sticky orphan flag.
- Requests in the cycle _clear is high are ignored.
- Reset: state IDLE. _mem_busy, _if_mem_done, _mem_lsb_ready, mem_wr = 0. _if_mem_data, _data_out, mem_a, mem_dout = 0. Round-robin pointer points to the fetcher.

## Timing
- Accept in cycle 0. Issues occur in cycles 1..N (no stalls).
- Load or fetch done in cycle N+2: word load or fetch = 6, half = 4, byte = 3.
- Store done in cycle N+1: word = 5, byte = 2.
- Each rdy_in-low or IO-stall cycle adds one cycle.
- mem_a, mem_dout and mem_wr are registered (gating aside). Done outputs are registered.

## Configuration
- MEM_CTRL_RR_EN defined: on a simultaneous request, the grant goes to the requester not granted most recently. A single requester is always granted, and the pointer is updated on every grant.
- MEM_CTRL_RR_EN undefined: the LSB has fixed priority and no pointer register exists.

## Structure
- Shared package mem_ctrl_pkg:
  - state encoding (IDLE/IF_RD/LS_RD/LS_WR)
  - work-type constants
  - IO address match constant (addr[17:16]==2'b11)
- One sub-module, mem_arbiter: grant logic plus the optional round-robin pointer.

## Test plan
- LSB word load at 0x1000, RAM bytes 11,22,33,44 -> `_mem_lsb_ready` in cycle 6, `_data_out` = 0x44332211, `_mem_busy` high in cycles 1–5.
- Half load at 0x1002, bytes 34,12 -> `_data_out` = 0x12340000 in cycle 4. Byte load of 0x80 -> 0x80000000 in cycle 3.
- Half store of 0x0000ABCD to 0x2000 -> (0x2000,CD,wr=1) in cycle 1, (0x2001,AB,wr=1) in cycle 2, done in cycle 3. A new LSB request in cycle 3 is accepted.
- Fetch and LSB requesting together, twice:
  - without RR: LSB, LSB.
  - with MEM_CTRL_RR_EN: fetch, then LSB.
- Byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr low for those cycles, then one write, done 3 cycles late.
- _clear in cycle 3 of a fetch -> IDLE next cycle, no `_if_mem_done`.
- _clear in cycle 2 of a word store -> all 4 bytes written, no `_mem_lsb_ready`.
- rdy_in low during a word load -> same data, done delayed by the low cycles, no extra writes.
